// File: rtl/crc32_frame_tx.sv
// Byte-stream to bit-serial transmitter: payload LSB first, then a CRC-32 trailer MSB first.
// Optional abort path (s_abort / tx_abort) is built when CRC32_TX_ABORT_EN is defined.
module crc32_frame_tx #(
    parameter logic [31:0] POLY         = 32'h04C11DB7,
    parameter int          CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
`ifdef CRC32_TX_ABORT_EN
    input  logic       s_abort,
    output logic       tx_abort,
`endif
    output logic       tx_bit,
    output logic       tx_valid,
    output logic       tx_crc,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, DATA, LOAD, CRC} state_t;

    state_t        state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic          last_q, last_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [4:0]    crc_cnt_q, crc_cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [31:0]   crc_q, crc_d;
    logic          rdy, bit_tick, abort_req;

    assign bit_tick = (div_q == CW'(CLKS_PER_BIT - 1));
    assign s_ready  = rdy & ~rst;

`ifdef CRC32_TX_ABORT_EN
    logic tx_abort_q;
    assign abort_req = s_abort & (state_q != IDLE);
    assign tx_abort  = tx_abort_q;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        last_d    = last_q;
        bit_cnt_d = bit_cnt_q;
        crc_cnt_d = crc_cnt_q;
        div_d     = div_q;
        crc_d     = crc_q;
        rdy       = 1'b0;
        tx_bit    = 1'b0;
        tx_valid  = 1'b0;
        tx_crc    = 1'b0;
        tx_done   = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (s_valid) begin
                    byte_d    = s_data;
                    last_d    = s_last;
                    crc_d     = '0;
                    bit_cnt_d = '0;
                    div_d     = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_bit   = byte_q[bit_cnt_q];
                div_d    = bit_tick ? '0 : div_q + 1'b1;
                if (bit_tick) begin
                    crc_d     = {crc_q[30:0], 1'b0} ^ (POLY & {32{crc_q[31] ^ byte_q[bit_cnt_q]}});
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (last_q) begin
                            crc_cnt_d = '0;
                            state_d   = CRC;
                        end else begin
                            // Back-to-back byte keeps the stream gapless; otherwise park in LOAD.
                            rdy = 1'b1;
                            if (s_valid) begin
                                byte_d = s_data;
                                last_d = s_last;
                            end else begin
                                state_d = LOAD;
                            end
                        end
                    end
                end
            end
            LOAD: begin
                rdy   = 1'b1;
                div_d = '0;
                if (s_valid) begin
                    byte_d    = s_data;
                    last_d    = s_last;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            CRC: begin
                tx_valid = 1'b1;
                tx_crc   = 1'b1;
                tx_bit   = crc_q[31];
                div_d    = bit_tick ? '0 : div_q + 1'b1;
                if (bit_tick) begin
                    crc_d     = {crc_q[30:0], 1'b0};
                    crc_cnt_d = crc_cnt_q + 5'd1;
                    if (crc_cnt_q == 5'd31) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any same-cycle handshake or completion.
        if (abort_req) begin
            state_d = IDLE;
            rdy     = 1'b0;
            tx_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            last_q    <= 1'b0;
            bit_cnt_q <= '0;
            crc_cnt_q <= '0;
            div_q     <= '0;
            crc_q     <= '0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            bit_cnt_q <= bit_cnt_d;
            crc_cnt_q <= crc_cnt_d;
            div_q     <= div_d;
            crc_q     <= crc_d;
        end
    end

`ifdef CRC32_TX_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_abort_q <= 1'b0;
        else     tx_abort_q <= abort_req;
    end
`endif
endmodule
